// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op-code encoding, FSM states
// and bit positions inside the packed flag vector.
package alu_pkg;

    localparam int OPW = 4;

    localparam logic [OPW-1:0] OP_PASSA = 4'h0;
    localparam logic [OPW-1:0] OP_NOTA  = 4'h1;
    localparam logic [OPW-1:0] OP_ADD   = 4'h2;
    localparam logic [OPW-1:0] OP_SUB   = 4'h3;
    localparam logic [OPW-1:0] OP_AND   = 4'h4;
    localparam logic [OPW-1:0] OP_OR    = 4'h5;
    localparam logic [OPW-1:0] OP_NEGA  = 4'h6;
    localparam logic [OPW-1:0] OP_NEGB  = 4'h7;
    localparam logic [OPW-1:0] OP_XOR   = 4'h8;
    localparam logic [OPW-1:0] OP_SHL   = 4'h9;
    localparam logic [OPW-1:0] OP_SHR   = 4'hA;
    localparam logic [OPW-1:0] OP_SAR   = 4'hB;
    localparam logic [OPW-1:0] OP_MULU  = 4'hC;
    localparam logic [OPW-1:0] OP_PASSB = 4'hD;
    localparam logic [OPW-1:0] OP_SLT   = 4'hE;
    localparam logic [OPW-1:0] OP_RSVD  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;
    localparam int FLG_W = 4;

endpackage

// File: rtl/alu_if.sv
// Operand/result handshake bundle between the operand muxes (master) and
// the sequential ALU (slave).
interface alu_if #(parameter int WIDTH = 16);
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OPW-1:0]   op_alu;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             zero;
    logic             carry;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, op_alu, out_ready,
        input  in_ready, out_valid, y, y_hi, zero, carry, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, op_alu, out_ready,
        output in_ready, out_valid, y, y_hi, zero, carry, neg, ovf
    );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU for every single-cycle op, with C/N/V/Z flag generation.
// MULU and the reserved code yield zero here; the multiplier lives in alu_seq.
module alu_core import alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] y,
    output logic [FLG_W-1:0] flags
);

    localparam int LW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic [LW-1:0]           sh;
    logic [WIDTH:0]          shl_ext;
    logic [WIDTH:0]          shr_ext;
    logic signed [WIDTH:0]   sar_ext;
    logic                    carry;
    logic                    ovf;

    assign a_s  = a;
    assign b_s  = b;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign sh   = b[LW-1:0];

    // One spare bit beside the operand catches the last bit shifted out,
    // which is also zero for a shift amount of zero.
    assign shl_ext = {1'b0, a} << sh;
    assign shr_ext = {a, 1'b0} >> sh;
    assign sar_ext = $signed({a, 1'b0}) >>> sh;

    always_comb begin
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_PASSA: y = a;
            OP_NOTA:  y = ~a;
            OP_ADD: begin
                y     = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y     = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_NEGA: begin
                y   = -a;
                ovf = (a == MIN_VAL);
            end
            OP_NEGB: begin
                y   = -b;
                ovf = (b == MIN_VAL);
            end
            OP_XOR:   y = a ^ b;
            OP_SHL: begin
                y     = shl_ext[WIDTH-1:0];
                carry = shl_ext[WIDTH];
            end
            OP_SHR: begin
                y     = shr_ext[WIDTH:1];
                carry = shr_ext[0];
            end
            OP_SAR: begin
                y     = sar_ext[WIDTH:1];
                carry = sar_ext[0];
            end
            OP_PASSB: y = b;
            OP_SLT:   y = (a_s < b_s) ? WIDTH'(1) : '0;
            default:  y = '0;
        endcase
    end

    assign flags[FLG_Z] = ~|y;
    assign flags[FLG_C] = carry;
    assign flags[FLG_N] = y[WIDTH-1];
    assign flags[FLG_V] = ovf;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides: single-cycle ops register
// at the accept edge, MULU runs a WIDTH-cycle shift-add loop.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH = 16
) (
    input logic  clk,
    input logic  reset,
    alu_if.slave bus
);

    localparam int LW = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               is_mul;
    logic               mul_last;
    logic [WIDTH-1:0]   core_y;
    logic [FLG_W-1:0]   core_flags;

    logic [2*WIDTH-1:0] mcand_p0;
    logic [WIDTH-1:0]   mplier_p0;
    logic [2*WIDTH-1:0] prod_p0;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [LW-1:0]      cnt_p0;

    logic [WIDTH-1:0]   y_p1;
    logic [WIDTH-1:0]   y_hi_p1;
    logic [FLG_W-1:0]   flags_p1;

    function automatic logic [FLG_W-1:0] mul_flags(input logic [WIDTH-1:0] lo,
                                                   input logic [WIDTH-1:0] hi);
        logic [FLG_W-1:0] f;
        f        = '0;
        f[FLG_Z] = ~|lo;
        f[FLG_C] = |hi;
        f[FLG_N] = lo[WIDTH-1];
        return f;
    endfunction

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a     (bus.a),
        .b     (bus.b),
        .op    (bus.op_alu),
        .y     (core_y),
        .flags (core_flags)
    );

    assign bus.in_ready  = !reset && ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
    assign bus.out_valid = (state == ST_DONE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (bus.op_alu == OP_MULU);
    assign mul_last      = (cnt_p0 == LW'(WIDTH - 1));
    assign prod_nxt      = mplier_p0[0] ? (prod_p0 + mcand_p0) : prod_p0;

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = is_mul ? ST_MUL : ST_DONE;
            ST_MUL:  if (mul_last) state_nxt = ST_DONE;
            ST_DONE: begin
                if (accept)             state_nxt = is_mul ? ST_MUL : ST_DONE;
                else if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stage p0: multiplier operands and running partial-product sum
    always_ff @(posedge clk) begin
        if (accept && is_mul) begin
            mcand_p0  <= {{WIDTH{1'b0}}, bus.a};
            mplier_p0 <= bus.b;
            prod_p0   <= '0;
        end else if (state == ST_MUL) begin
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            prod_p0   <= prod_nxt;
        end
    end

    // Stage p1: result and flags held until the consumer takes them
    always_ff @(posedge clk) begin
        if (reset) begin
            y_p1     <= '0;
            y_hi_p1  <= '0;
            flags_p1 <= '0;
            cnt_p0   <= '0;
        end else if (accept) begin
            if (is_mul) begin
                cnt_p0 <= '0;
            end else begin
                y_p1     <= core_y;
                y_hi_p1  <= '0;
                flags_p1 <= core_flags;
            end
        end else if (state == ST_MUL) begin
            cnt_p0 <= cnt_p0 + LW'(1);
            if (mul_last) begin
                y_p1     <= prod_nxt[WIDTH-1:0];
                y_hi_p1  <= prod_nxt[2*WIDTH-1:WIDTH];
                flags_p1 <= mul_flags(prod_nxt[WIDTH-1:0], prod_nxt[2*WIDTH-1:WIDTH]);
            end
        end
    end

    assign bus.y     = y_p1;
    assign bus.y_hi  = y_hi_p1;
    assign bus.zero  = flags_p1[FLG_Z];
    assign bus.carry = flags_p1[FLG_C];
    assign bus.neg   = flags_p1[FLG_N];
    assign bus.ovf   = flags_p1[FLG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16: expected results are queued when
// an op is driven and compared when the ALU hands a result over.
`timescale 1ns/1ps
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] y;
        logic [W-1:0] yh;
        logic [3:0]   f;   // {ovf, neg, carry, zero}
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_if #(.WIDTH(W)) bus();

    alu_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int sa, sb, r, sh;
        logic [2*W-1:0] p;
        logic c, v;
        e  = '0;
        c  = 1'b0;
        v  = 1'b0;
        sh = int'(b[3:0]);
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            OP_PASSA: e.y = a;
            OP_NOTA:  e.y = ~a;
            OP_ADD: begin
                e.y = a + b;
                c   = (int'(a) + int'(b)) > 65535;
                r   = sa + sb;
                v   = (r > 32767) || (r < -32768);
            end
            OP_SUB: begin
                e.y = a - b;
                c   = a < b;
                r   = sa - sb;
                v   = (r > 32767) || (r < -32768);
            end
            OP_AND:   e.y = a & b;
            OP_OR:    e.y = a | b;
            OP_NEGA: begin e.y = -a; v = (a == 16'h8000); end
            OP_NEGB: begin e.y = -b; v = (b == 16'h8000); end
            OP_XOR:   e.y = a ^ b;
            OP_SHL: begin e.y = a << sh; c = (sh != 0) ? a[W-sh] : 1'b0; end
            OP_SHR: begin e.y = a >> sh; c = (sh != 0) ? a[sh-1] : 1'b0; end
            OP_SAR: begin e.y = $signed(a) >>> sh; c = (sh != 0) ? a[sh-1] : 1'b0; end
            OP_MULU: begin
                p    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.y  = p[W-1:0];
                e.yh = p[2*W-1:W];
                c    = |e.yh;
            end
            OP_PASSB: e.y = b;
            OP_SLT:   e.y = (sa < sb) ? 16'd1 : 16'd0;
            default:  e.y = '0;
        endcase
        e.f = {v, e.y[W-1], c, (e.y == '0)};
        return e;
    endfunction

    // Result monitor: a result is consumed when out_valid & out_ready meet at an edge
    always begin
        @(negedge clk);
        #3;
        if (!reset && bus.out_valid && bus.out_ready) begin
            check_eq("sb_nonempty", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("res_y", bus.y, mon_e.y);
                check_eq("res_y_hi", bus.y_hi, mon_e.yh);
                check_eq("res_flags", {bus.ovf, bus.neg, bus.carry, bus.zero}, mon_e.f);
            end
        end
    end

    task automatic drive_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.op_alu   = op;
        bus.a        = a;
        bus.b        = b;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("accept_in_time", (n < 200), 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.op_alu   = 4'($urandom_range(0, 15));
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_q.push_back(model(op, a, b));
        drive_op(op, a, b);
    endtask

    task automatic send_k(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ey, input logic [W-1:0] eyh, input logic [3:0] ef);
        exp_t e;
        e.y  = ey;
        e.yh = eyh;
        e.f  = ef;
        exp_q.push_back(e);
        drive_op(op, a, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rdy_hi, vld_hi;
        logic [63:0] held;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = '0;
        bus.b         = '0;
        bus.op_alu    = OP_PASSA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_y", {bus.y, bus.y_hi}, 0);
        check_eq("rst_flags", {bus.ovf, bus.neg, bus.carry, bus.zero}, 0);
        reset = 1'b0;
        #1;
        check_eq("idle_in_ready", bus.in_ready, 1);

        send_k(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b1100);
        check_eq("add_latency", bus.out_valid, 1);

        c0 = cyc;
        send_k(OP_SUB,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 4'b0001);
        send_k(OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 4'b0110);
        send_k(OP_SAR,  16'h8000, 16'h0004, 16'hF800, 16'h0000, 4'b0100);
        send_k(OP_SHL,  16'h8001, 16'h0001, 16'h0002, 16'h0000, 4'b0010);
        send_k(OP_SHL,  16'h1234, 16'h0010, 16'h1234, 16'h0000, 4'b0000);
        send_k(OP_RSVD, 16'h0005, 16'h0003, 16'h0000, 16'h0000, 4'b0001);
        check_eq("throughput", cyc - c0, 6);

        send(OP_NEGA, 16'h8000, 16'h1111);
        send(OP_NEGB, 16'h2222, 16'h8000);
        send(OP_SLT,  16'hFFFF, 16'h0001);
        send(OP_SLT,  16'h0001, 16'hFFFF);
        send(OP_SHR,  16'h8001, 16'h000F);
        send(OP_SUB,  16'h8000, 16'h0001);
        for (int i = 0; i < 24; i++)
            send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));

        send_k(OP_MULU, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b0010);
        rdy_hi = 0;
        vld_hi = 0;
        for (int k = 0; k < 16; k++) begin
            rdy_hi += int'(bus.in_ready);
            vld_hi += int'(bus.out_valid);
            @(negedge clk);
        end
        check_eq("mul_in_ready_low", rdy_hi, 0);
        check_eq("mul_out_valid_low", vld_hi, 0);
        check_eq("mul_latency", bus.out_valid, 1);
        send(OP_MULU, 16'hFFFF, 16'hFFFF);
        send(OP_MULU, W'($urandom), W'($urandom));

        repeat (20) @(negedge clk);
        bus.out_ready = 1'b0;
        send_k(OP_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00, 16'h0000, 4'b0100);
        held = {16'h0, bus.y, bus.y_hi, 12'h0, bus.ovf, bus.neg, bus.carry, bus.zero};
        fork
            send_k(OP_AND, 16'h0F0F, 16'h00FF, 16'h000F, 16'h0000, 4'b0000);
            begin
                for (int k = 0; k < 5; k++) begin
                    check_eq("hold_stable",
                             {16'h0, bus.y, bus.y_hi, 12'h0, bus.ovf, bus.neg, bus.carry, bus.zero}, held);
                    check_eq("hold_no_accept", {bus.out_valid, bus.in_ready}, 2'b10);
                    @(negedge clk);
                end
                c0 = cyc;
                bus.out_ready = 1'b1;
            end
        join
        check_eq("release_same_edge", cyc - c0, 1);

        repeat (2) @(negedge clk);
        send(OP_MULU, 16'h00FF, 16'h0003);
        void'(exp_q.pop_back());
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_out_valid", bus.out_valid, 0);
        check_eq("abort_y", {bus.y, bus.y_hi}, 0);
        check_eq("abort_flags", {bus.ovf, bus.neg, bus.carry, bus.zero}, 0);
        check_eq("abort_in_ready_in_reset", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        check_eq("abort_in_ready", bus.in_ready, 1);
        repeat (20) @(negedge clk);
        send_k(OP_ADD, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 4'b0000);

        repeat (5) @(negedge clk);
        check_eq("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
